stepdown_deadtime_seq: RTL and testbench

Break-before-make sequencer for the stepdown power stage. Converts a PWM request into mutually exclusive high-side and low-side gate enables, inserting a dead time between them. Each dead time requires a programmable cycle count and a completed round trip through the stepdown fixed 1 ns both-edge delay cell. A sticky fault is raised if the delay cell's echo never returns.

---
 rtl/stepdown_seq_pkg.sv | 23 ++
 rtl/stepdown_deadtime_seq_if.sv | 29 ++
 rtl/stepdown_echo_sync.sv | 22 ++
 rtl/stepdown_deadtime_seq.sv | 96 +++++++++
 tb/tb_stepdown_deadtime_seq.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/stepdown_seq_pkg.sv
// stepdown_seq_pkg: shared state type and defaults for the stepdown dead-time sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: stepdown_dt_state_t, default dead-time width, default echo timeout, dead-time state test.
package stepdown_seq_pkg;

   typedef enum logic [2:0] {
      OFF   = 3'd0,
      LS_ON = 3'd1,
      DT_LH = 3'd2,
      HS_ON = 3'd3,
      DT_HL = 3'd4,
      FAULT = 3'd5
   } stepdown_dt_state_t;

   localparam int STEPDOWN_DT_W   = 6;
   localparam int STEPDOWN_TO_CYC = 15;   // must stay below 2**DT_W

   function automatic logic is_dt(input stepdown_dt_state_t s);
      return (s == DT_LH) || (s == DT_HL);
   endfunction

endpackage

// File: rtl/stepdown_deadtime_seq_if.sv
// stepdown_deadtime_seq_if: control/status bundle between the stage controller and the sequencer.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level-sampled every cycle.
// master drives en, pwm_req, dt_cfg and the delay-cell echo dly_o; slave drives dly_i, gates, busy, fault.
interface stepdown_deadtime_seq_if
   import stepdown_seq_pkg::*;
#(
   parameter int DT_W = STEPDOWN_DT_W
);
   logic            en;
   logic            pwm_req;
   logic [DT_W-1:0] dt_cfg;
   logic            dly_o;
   logic            dly_i;
   logic            hs_on;
   logic            ls_on;
   logic            busy;
   logic            fault;

   modport master (
      output en, pwm_req, dt_cfg, dly_o,
      input  dly_i, hs_on, ls_on, busy, fault
   );

   modport slave (
      input  en, pwm_req, dt_cfg, dly_o,
      output dly_i, hs_on, ls_on, busy, fault
   );
endinterface

// File: rtl/stepdown_echo_sync.sv
// stepdown_echo_sync: two-flop synchroniser bringing the asynchronous delay-cell output into CELCLK.
// Latency: 2 cycles from d settling to q.
// Backpressure: none.
// Ports: CELCLK clock, CELRSTN sync active-low reset (q resets to 0), d async input, q synchronised output.
module stepdown_echo_sync (
   input  logic CELCLK,
   input  logic CELRSTN,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge CELCLK) begin
      if (!CELRSTN) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/stepdown_deadtime_seq.sv
// stepdown_deadtime_seq: break-before-make sequencer turning pwm_req into mutually exclusive hs_on/ls_on.
// Latency: gate fall 1 cycle after request sample; gate rise max(dt_q,2)+1 cycles after dead-time entry.
// Backpressure: none; pwm_req changes during a dead time wait until the target gate has been on one cycle.
// Ports: CELCLK clock, CELRSTN sync active-low reset; bus (slave) takes en, pwm_req, dt_cfg, dly_o and
//        returns dly_i, hs_on, ls_on, busy, fault.  All outputs are registered.
// Build option STEPDOWN_DT_ECHO_EN: enables the delay-cell round trip (dly_i/dly_o) and echo-timeout fault.
//        Without it dly_i stays 0, dly_o is ignored, rise is at dt_q+1 and fault never asserts.
module stepdown_deadtime_seq
   import stepdown_seq_pkg::*;
#(
   parameter int DT_W   = STEPDOWN_DT_W,
   parameter int TO_CYC = STEPDOWN_TO_CYC
) (
   input  logic                  CELCLK,
   input  logic                  CELRSTN,
   stepdown_deadtime_seq_if.slave bus
);

`ifdef STEPDOWN_DT_ECHO_EN
   localparam bit ECHO_EN = 1'b1;
`else
   localparam bit ECHO_EN = 1'b0;
`endif

   localparam logic [DT_W-1:0] TO_V = DT_W'(TO_CYC);

   stepdown_dt_state_t state, nxt;
   logic [DT_W-1:0]    cnt, dt_q;
   logic               dly_i_q, hs_q, ls_q, busy_q, fault_q;
   logic               dly_o_sync;
   logic               echo_ok, done, timeout, dt_entry;

   stepdown_echo_sync u_echo_sync (
      .CELCLK  (CELCLK),
      .CELRSTN (CELRSTN),
      .d       (bus.dly_o),
      .q       (dly_o_sync)
   );

   // The echo has returned once the synchronised cell output matches what we last drove.
   assign echo_ok  = ECHO_EN ? (dly_o_sync == dly_i_q) : 1'b1;
   assign done     = (cnt >= dt_q) && echo_ok;
   assign timeout  = ECHO_EN && !echo_ok && (cnt == TO_V);
   assign dt_entry = is_dt(nxt) && !is_dt(state);

   always_comb begin
      nxt = state;
      case (state)
         OFF:     if (bus.en)       nxt = LS_ON;
         LS_ON:   if (bus.pwm_req)  nxt = DT_LH;
         HS_ON:   if (!bus.pwm_req) nxt = DT_HL;
         DT_LH:   if (timeout)      nxt = FAULT;
                  else if (done)    nxt = HS_ON;
         DT_HL:   if (timeout)      nxt = FAULT;
                  else if (done)    nxt = LS_ON;
         FAULT:                     nxt = FAULT;
         default:                   nxt = OFF;
      endcase
      // Dropping enable wins over everything, including a dead time that is just completing.
      if (!bus.en) nxt = OFF;
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge CELCLK) begin
      if (!CELRSTN) begin
         state   <= OFF;
         cnt     <= '0;
         dt_q    <= '0;
         dly_i_q <= 1'b0;
         hs_q    <= 1'b0;
         ls_q    <= 1'b0;
         busy_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state   <= nxt;
         hs_q    <= (nxt == HS_ON);
         ls_q    <= (nxt == LS_ON);
         busy_q  <= is_dt(nxt);
         fault_q <= (nxt == FAULT);
         if (dt_entry) begin
            cnt     <= '0;
            dt_q    <= bus.dt_cfg;
            dly_i_q <= ECHO_EN & ~dly_i_q;   // one edge launched into the delay cell per dead time
         end else if (is_dt(state) && (cnt != '1)) begin
            cnt <= cnt + DT_W'(1);
         end
      end
   end

   assign bus.dly_i = dly_i_q;
   assign bus.hs_on = hs_q;
   assign bus.ls_on = ls_q;
   assign bus.busy  = busy_q;
   assign bus.fault = fault_q;

endmodule

// File: tb/tb_stepdown_deadtime_seq.sv
// tb_stepdown_deadtime_seq: scoreboard bench for the dead-time sequencer.
// Latency: expectations are queued per clock edge and popped 1 ns after that edge.
// Backpressure: none; the monitor consumes one expected output vector per edge.
module tb_stepdown_deadtime_seq;

`ifdef STEPDOWN_DT_ECHO_EN
   localparam bit ECHO = 1'b1;
`else
   localparam bit ECHO = 1'b0;
`endif
   localparam int DT_W   = 6;
   localparam int TO_CYC = 15;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic cell_o = 1'b0;
   logic stuck  = 1'b0;

   stepdown_deadtime_seq_if #(.DT_W(DT_W)) dut_if ();
   assign dut_if.dly_o = cell_o;

   stepdown_deadtime_seq #(.DT_W(DT_W), .TO_CYC(TO_CYC)) dut (
      .CELCLK  (clk),
      .CELRSTN (rst_n),
      .bus     (dut_if.slave)
   );

   always #5 clk = ~clk;

`ifdef STEPDOWN_DT_ECHO_EN
   // Delay cell: 1 ns both-edge delay, or frozen while stuck.
   always @(dut_if.dly_i or stuck) begin
      #1;
      if (!stuck) cell_o = dut_if.dly_i;
   end
`else
   bit noise = 1'b1;
`endif

   // Scoreboard: {hs_on, ls_on, busy, fault, dly_i} expected after each edge.
   logic [4:0] exp_q[$];
   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: time-stamped view of the power stage.
   // gate: 0 none, 1 low side, 2 high side.
   int edge_n   = 0;
   int m_gate   = 0;
   int m_target = 0;
   bit m_in_dt  = 1'b0;
   bit m_fault  = 1'b0;
   bit m_par    = 1'b0;
   int rise_at  = -1;
   int fault_at = -1;

   task automatic start_dt(input int tgt, input int dt);
      int wait_c;
      m_in_dt  = 1'b1;
      m_gate   = 0;
      m_target = tgt;
      if (ECHO) m_par = ~m_par;
      wait_c = ECHO ? ((dt < 2) ? 2 : dt) : dt;
      if (ECHO && stuck) begin
         rise_at  = -1;
         fault_at = edge_n + TO_CYC + 1;
      end else begin
         rise_at  = edge_n + wait_c + 1;
         fault_at = -1;
      end
   endtask

   task automatic step(input bit r, input bit e, input bit p, input int dt);
      rst_n          = r;
      dut_if.en      = e;
      dut_if.pwm_req = p;
      dut_if.dt_cfg  = dt[DT_W-1:0];
`ifndef STEPDOWN_DT_ECHO_EN
      if (noise) cell_o = 1'($urandom_range(0, 1));
`endif
      edge_n++;
      if (!r) begin
         m_gate = 0; m_in_dt = 1'b0; m_fault = 1'b0; m_par = 1'b0;
      end else if (!e) begin
         m_gate = 0; m_in_dt = 1'b0; m_fault = 1'b0;
      end else if (m_fault) begin
         m_gate = 0;
      end else if (m_in_dt) begin
         if (edge_n == rise_at) begin
            m_gate  = m_target;
            m_in_dt = 1'b0;
         end else if (edge_n == fault_at) begin
            m_in_dt = 1'b0;
            m_fault = 1'b1;
         end
      end else if (m_gate == 0) begin
         m_gate = 1;
      end else if (m_gate == 1 && p) begin
         start_dt(2, dt);
      end else if (m_gate == 2 && !p) begin
         start_dt(1, dt);
      end
      exp_q.push_back({m_gate == 2, m_gate == 1, m_in_dt, m_fault, m_par});
      @(negedge clk);
   endtask

   // Monitor: compares DUT outputs 1 ns after every rising edge.
   initial begin : monitor
      logic [4:0] got;
      logic [4:0] want;
      int cyc;
      cyc = 0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         got = {dut_if.hs_on, dut_if.ls_on, dut_if.busy, dut_if.fault, dut_if.dly_i};
         n_chk++;
         if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_empty cyc %0d: got %b, nothing expected", cyc, got);
         end else begin
            want = exp_q.pop_front();
            if (got === want) n_pass++;
            else $display("FAIL outputs cyc %0d: hs/ls/busy/fault/dly_i got %b want %b", cyc, got, want);
         end
         n_chk++;
         if ((dut_if.hs_on & dut_if.ls_on) === 1'b0) n_pass++;
         else $display("FAIL overlap cyc %0d: hs_on=%b ls_on=%b want not both 1", cyc, dut_if.hs_on, dut_if.ls_on);
      end
   end

   initial begin : stimulus
      dut_if.en      = 1'b1;
      dut_if.pwm_req = 1'b0;
      dut_if.dt_cfg  = '0;

      // Reset held with en=1, then low side on at the first edge after release.
      repeat (3) step(1'b0, 1'b1, 1'b0, 0);
      repeat (3) step(1'b1, 1'b1, 1'b0, 0);

      // Low to high with dt_cfg=8, then high to low with dt_cfg=0.
      repeat (14) step(1'b1, 1'b1, 1'b1, 8);
      repeat (6)  step(1'b1, 1'b1, 1'b0, 0);

`ifdef STEPDOWN_DT_ECHO_EN
      // Echo never returns: fault at E(TO_CYC+1), sticky until en drops.
      stuck = 1'b1;
      repeat (20) step(1'b1, 1'b1, 1'b1, 3);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, i[0], 3);
      repeat (2) step(1'b1, 1'b0, 1'b0, 3);
      stuck = 1'b0;
      repeat (3) step(1'b1, 1'b0, 1'b0, 3);
      repeat (3) step(1'b1, 1'b1, 1'b0, 3);
`else
      // Echo compiled out: a frozen dly_o must not matter, rise at E(dt+1).
      noise  = 1'b0;
      cell_o = 1'b0;
      repeat (8) step(1'b1, 1'b1, 1'b1, 4);
      repeat (6) step(1'b1, 1'b1, 1'b0, 4);
      noise  = 1'b1;
`endif

      // Enable dropped in the middle of a dead time, then re-enabled.
      repeat (2) step(1'b1, 1'b1, 1'b1, 10);
      step(1'b1, 1'b0, 1'b1, 10);
      repeat (5) step(1'b1, 1'b1, 1'b0, 0);

      // pwm_req toggling every cycle with random dead times and rare enable drops.
      for (int i = 0; i < 200; i++) begin
         automatic int dtr;
         automatic bit ena;
         dtr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 40)) : int'($urandom_range(0, 6));
         ena = ($urandom_range(0, 39) != 0);
         step(1'b1, ena, i[0], dtr);
      end

      // Hold high side request long enough to settle.
      repeat (12) step(1'b1, 1'b1, 1'b1, 5);

      n_chk++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d expectations left, want 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
